// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, typedefs and the load sequencer state type
// for the sprite store loader.
// Optional feature macro: SPRITE_LOAD_TIMEOUT_EN adds the ABORT state.
package sprite_pkg;

  localparam int unsigned NUM_SPRITES = 32;
  localparam int unsigned ROWS        = 19;
  localparam int unsigned ROW_W       = 19;

  typedef logic [4:0]       sprite_id_t;
  typedef logic [ROW_W-1:0] sprite_row_t;

`ifdef SPRITE_LOAD_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE,
    ST_ABORT
  } load_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE
  } load_state_t;
`endif

endpackage

// File: rtl/sprite_rd_arb.sv
// sprite_rd_arb: IDLE-state arbitration between renderer reads and host
// load requests. Reads win until a waiting load has been passed over
// STARVE_LIMIT times in a row; then the load is granted.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   idle            sequencer is in IDLE (grants only issued then)
//   rd_req          renderer read request
//   req_valid       host load request present
//   grant_rd        read issued this cycle
//   grant_load      load request accepted this cycle
module sprite_rd_arb #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic rd_req,
  input  logic req_valid,
  output logic grant_rd,
  output logic grant_load
);

  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_rd     = 1'b0;
    grant_load   = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (!req_valid) begin
      starve_cnt_d = '0;
    end
    // Grants are combinational handshakes; mask them while reset is held
    // so every output is quiet during reset.
    if (idle && !rst) begin
      if (rd_req && (starve_cnt_q < LIMIT)) begin
        grant_rd = 1'b1;
        if (req_valid) begin
          starve_cnt_d = starve_cnt_q + CW'(1);
        end
      end else if (req_valid) begin
        grant_load   = 1'b1;
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/sprite_load_ctrl.sv
// sprite_load_ctrl: sequences host loads into the 19x19 sprite store and
// shares the store with renderer reads. A load is one clear cycle for the
// target sprite followed by exactly ROWS row writes, then a done pulse.
// Optional feature macro: SPRITE_LOAD_TIMEOUT_EN (row-stall timeout ->
// ABORT, which re-clears the sprite and pulses load_err).
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_id/req_ready     load request handshake
//   row_valid/row_data/row_ready   row beat stream, row 0 first
//   rd_req/rd_addr/rd_grant        renderer read (data valid next cycle)
//   rom_addr/rom_data/rom_write/rom_clear   store control
//   busy                           not IDLE
//   load_done/load_err             1-cycle completion / rejection pulses
module sprite_load_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 32,
  parameter int unsigned STARVE_LIMIT = 16
`ifdef SPRITE_LOAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT      = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [4:0]       req_id,
  output logic             req_ready,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  output logic             row_ready,
  input  logic             rd_req,
  input  logic [4:0]       rd_addr,
  output logic             rd_grant,
  output logic [4:0]       rom_addr,
  output logic [ROW_W-1:0] rom_data,
  output logic             rom_write,
  output logic             rom_clear,
  output logic             busy,
  output logic             load_done,
  output logic             load_err
);

  load_state_t state_q, state_d;
  sprite_id_t  cur_id_q, cur_id_d;
  logic [4:0]  row_cnt_q, row_cnt_d;
  logic        load_err_q, load_err_d;
  logic        idle, grant_rd, grant_load;

`ifdef SPRITE_LOAD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt_q, stall_cnt_d;
`endif

  assign idle = (state_q == ST_IDLE);

  sprite_rd_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk       (clk),
    .rst       (reset),
    .idle      (idle),
    .rd_req    (rd_req),
    .req_valid (req_valid),
    .grant_rd  (grant_rd),
    .grant_load(grant_load)
  );

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    row_cnt_d  = row_cnt_q;
    load_err_d = 1'b0;
`ifdef SPRITE_LOAD_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    rd_grant  = 1'b0;
    req_ready = 1'b0;
    row_ready = 1'b0;
    rom_addr  = '0;
    rom_data  = '0;
    rom_write = 1'b0;
    rom_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rd_grant  = grant_rd;
        req_ready = grant_load;
        if (grant_rd) begin
          rom_addr = rd_addr;
        end
        if (grant_load) begin
          cur_id_d = req_id;
          if (32'(req_id) >= NUM_SPRITES) begin
            load_err_d = 1'b1;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        rom_clear = 1'b1;
        rom_addr  = cur_id_q;
        row_cnt_d = '0;
`ifdef SPRITE_LOAD_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        row_ready = 1'b1;
        rom_addr  = cur_id_q;
        rom_data  = row_data;
        rom_write = row_valid;
        if (row_valid) begin
`ifdef SPRITE_LOAD_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (row_cnt_q == 5'(ROWS - 1)) begin
            row_cnt_d = '0;
            state_d   = ST_DONE;
          end else begin
            row_cnt_d = row_cnt_q + 5'd1;
          end
        end
`ifdef SPRITE_LOAD_TIMEOUT_EN
        else if (stall_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          stall_cnt_d = stall_cnt_q + TW'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef SPRITE_LOAD_TIMEOUT_EN
      ST_ABORT: begin
        rom_clear = 1'b1;
        rom_addr  = cur_id_q;
        state_d   = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign load_done = (state_q == ST_DONE);
`ifdef SPRITE_LOAD_TIMEOUT_EN
  assign load_err  = load_err_q | (state_q == ST_ABORT);
`else
  assign load_err  = load_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_id_q    <= '0;
      row_cnt_q   <= '0;
      load_err_q  <= 1'b0;
`ifdef SPRITE_LOAD_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      row_cnt_q   <= row_cnt_d;
      load_err_q  <= load_err_d;
`ifdef SPRITE_LOAD_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sprite_load_ctrl.sv
// Self-checking bench for sprite_load_ctrl (NUM_SPRITES overridden to 16).
module tb_sprite_load_ctrl;
  import sprite_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [4:0]       req_id;
  logic             req_ready;
  logic             row_valid;
  logic [ROW_W-1:0] row_data;
  logic             row_ready;
  logic             rd_req;
  logic [4:0]       rd_addr;
  logic             rd_grant;
  logic [4:0]       rom_addr;
  logic [ROW_W-1:0] rom_data;
  logic             rom_write;
  logic             rom_clear;
  logic             busy;
  logic             load_done;
  logic             load_err;

  sprite_load_ctrl #(
    .NUM_SPRITES (16),
    .STARVE_LIMIT(16)
`ifdef SPRITE_LOAD_TIMEOUT_EN
    ,
    .TIMEOUT     (8)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_id   (req_id),
    .req_ready(req_ready),
    .row_valid(row_valid),
    .row_data (row_data),
    .row_ready(row_ready),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_grant (rd_grant),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_write(rom_write),
    .rom_clear(rom_clear),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_wr, n_clr, n_done, n_err, n_grant;

  typedef struct {
    logic       rd_req;
    logic [4:0] rd_addr;
    logic       req_valid;
    logic [4:0] req_id;
    logic       row_valid;
    logic       e_rd_grant;
    logic       e_req_ready;
    logic [4:0] e_rom_addr;
    logic       e_row_ready;
    logic       e_rom_write;
    logic       e_rom_clear;
    logic       e_busy;
    logic       e_load_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tally();
    if (rom_write) n_wr++;
    if (rom_clear) n_clr++;
    if (load_done) n_done++;
    if (load_err)  n_err++;
    if (rd_grant)  n_grant++;
  endtask

  task automatic zero_counts();
    n_wr = 0; n_clr = 0; n_done = 0; n_err = 0; n_grant = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      busy,      0);
    check({tag, " req_ready"}, req_ready, 0);
    check({tag, " row_ready"}, row_ready, 0);
    check({tag, " rd_grant"},  rd_grant,  0);
    check({tag, " rom_addr"},  rom_addr,  0);
    check({tag, " rom_data"},  rom_data,  0);
    check({tag, " rom_write"}, rom_write, 0);
    check({tag, " rom_clear"}, rom_clear, 0);
    check({tag, " load_done"}, load_done, 0);
    check({tag, " load_err"},  load_err,  0);
  endtask

  // Accept a request for id (req_ready must be high in the current cycle).
  task automatic accept(input logic [4:0] id, input string tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_id    = id;
    #1;
    zero_counts();
    check({tag, " req_ready"}, req_ready, 1);
  endtask

  // Everything after the acceptance cycle: clear, ROWS beats (with an
  // optional gap once gap_at beats have been sent), done, back to idle.
  task automatic finish_load(input logic [4:0] id, input int gap_at, input int gap_len,
                             input string tag);
    int cyc;
    int beats;
    int gap;
    cyc = 0; beats = 0; gap = 0;
    @(negedge clk);
    req_valid = 1'b0;
    #1; cyc++; tally();
    check({tag, " clear strobe"}, rom_clear, 1);
    check({tag, " clear addr"},   rom_addr,  id);
    check({tag, " clear busy"},   busy,      1);
    check({tag, " clear no write"}, rom_write, 0);
    while (beats < 19 && cyc < 80) begin
      @(negedge clk);
      if (beats == gap_at && gap < gap_len) begin
        row_valid = 1'b0;
        row_data  = '0;
        gap++;
      end else begin
        row_valid = 1'b1;
        row_data  = ROW_W'(1) << beats;
        beats++;
      end
      #1; cyc++; tally();
      if (row_valid) begin
        check($sformatf("%s beat%0d data", tag, beats - 1), rom_data, row_data);
        check($sformatf("%s beat%0d addr", tag, beats - 1), rom_addr, id);
        check($sformatf("%s beat%0d write", tag, beats - 1), rom_write, 1);
      end else begin
        check({tag, " gap write"}, rom_write, 0);
        check({tag, " gap row_ready"}, row_ready, 1);
      end
    end
    @(negedge clk);
    row_valid = 1'b0;
    row_data  = '0;
    #1; cyc++; tally();
    check({tag, " load_done"}, load_done, 1);
    check({tag, " done latency"}, cyc, 21 + gap_len);
    check({tag, " write count"}, n_wr, 19);
    check({tag, " clear count"}, n_clr, 1);
    check({tag, " grants during load"}, n_grant, 0);
    check({tag, " done row_ready"}, row_ready, 0);
    @(negedge clk);
    #1;
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle load_done"}, load_done, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1; req_valid = 0; req_id = 0; row_valid = 0; row_data = 0;
    rd_req = 0; rd_addr = 0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // rd_req rd_addr req_valid req_id row_valid | grant ready addr rowrdy wr clr busy err
    vecs[0]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd31, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd9,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  1'b1, 5'd20, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd2,  1'b1, 5'd20, 1'b0, 1'b1, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_req    = vecs[i].rd_req;
      rd_addr   = vecs[i].rd_addr;
      req_valid = vecs[i].req_valid;
      req_id    = vecs[i].req_id;
      row_valid = vecs[i].row_valid;
      row_data  = vecs[i].row_valid ? 19'h5A5A5 : 19'h0;
      #1;
      check($sformatf("vec%0d rd_grant", i),  rd_grant,  vecs[i].e_rd_grant);
      check($sformatf("vec%0d req_ready", i), req_ready, vecs[i].e_req_ready);
      check($sformatf("vec%0d rom_addr", i),  rom_addr,  vecs[i].e_rom_addr);
      check($sformatf("vec%0d row_ready", i), row_ready, vecs[i].e_row_ready);
      check($sformatf("vec%0d rom_write", i), rom_write, vecs[i].e_rom_write);
      check($sformatf("vec%0d rom_clear", i), rom_clear, vecs[i].e_rom_clear);
      check($sformatf("vec%0d busy", i),      busy,      vecs[i].e_busy);
      check($sformatf("vec%0d load_err", i),  load_err,  vecs[i].e_load_err);
    end
    @(negedge clk);
    rd_req = 0; rd_addr = 0; req_valid = 0; req_id = 0; row_valid = 0; row_data = 0;

    // Single load, back-to-back beats.
    accept(5'd5, "single");
    finish_load(5'd5, 99, 0, "single");

    // Gapped rows: 3 idle cycles after 10 beats.
    accept(5'd9, "gapped");
    finish_load(5'd9, 10, 3, "gapped");

    // Starvation: reads held high, load accepted on cycle 17.
    k = 0;
    zero_counts();
    while (k < 40) begin
      @(negedge clk);
      if (k == 0) begin
        rd_req = 1'b1; rd_addr = 5'd1; req_valid = 1'b1; req_id = 5'd3;
      end
      #1;
      k++;
      if (req_ready) break;
      tally();
    end
    check("starve accept cycle", k, 17);
    check("starve reads granted before", n_grant, 16);
    check("starve rd_grant at accept", rd_grant, 0);
    zero_counts();
    finish_load(5'd3, 99, 0, "starve");
    check("starve read resumes", rd_grant, 1);
    check("starve read addr", rom_addr, 5'd1);
    @(negedge clk);
    rd_req = 0;

    // Reset during LOAD after 8 beats.
    accept(5'd6, "rstmid");
    @(negedge clk);
    req_valid = 0;
    for (int b = 0; b < 9; b++) begin
      @(negedge clk);
      row_valid = 1'b1;
      row_data  = ROW_W'(b + 1);
    end
    rd_req = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("rstmid");
    @(negedge clk);
    reset = 1'b0; rd_req = 0; row_valid = 0; row_data = 0;
    accept(5'd6, "reload");
    finish_load(5'd6, 99, 0, "reload");

`ifdef SPRITE_LOAD_TIMEOUT_EN
    // Stall 8 cycles after 2 beats -> abort.
    accept(5'd2, "tmo");
    @(negedge clk);
    req_valid = 0;
    #1; tally();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      row_valid = 1'b1; row_data = ROW_W'(b + 1);
      #1; tally();
    end
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      row_valid = 1'b0; row_data = 0;
      #1; tally();
      check($sformatf("tmo stall%0d busy", s), busy, 1);
    end
    @(negedge clk);
    #1; tally();
    check("tmo abort clear", rom_clear, 1);
    check("tmo abort addr", rom_addr, 5'd2);
    check("tmo abort err", load_err, 1);
    check("tmo abort no done", load_done, 0);
    @(negedge clk);
    #1; tally();
    check("tmo idle busy", busy, 0);
    check("tmo clear count", n_clr, 2);
    check("tmo err count", n_err, 1);
    check("tmo done count", n_done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
